// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 12;

    function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned n);
        return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/adder_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, wrapping to 0.
module adder_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            grant_vld,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % NREQ);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters.
// Optional rsp_ovf overflow flag enabled by defining ADDER_ARB_OVF_EN.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      adder_a,
    output logic [WIDTH-1:0]      adder_b,
    output logic                  adder_cin,
    input  logic [WIDTH-1:0]      adder_sum,
    input  logic                  adder_cout,
`ifdef ADDER_ARB_OVF_EN
    output logic                  rsp_ovf,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    arb_state_e       state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
    logic             op_cin_q, cout_q;
    logic [IDW-1:0]   id_q;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;

    adder_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // Acceptance strobe is combinational so the grant and the handshake share one cycle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            id_q     <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        op_a_q   <= req_a[grant_id*WIDTH +: WIDTH];
                        op_b_q   <= req_b[grant_id*WIDTH +: WIDTH];
                        op_cin_q <= req_cin[grant_id];
                        id_q     <= grant_id;
                        rr_ptr_q <= IDW'(next_ptr(32'(grant_id), NREQ));
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    sum_q   <= adder_sum;
                    cout_q  <= adder_cout;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == CALC) begin
            ovf_q <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                     (adder_sum[WIDTH-1] != op_a_q[WIDTH-1]);
        end
    end

    assign rsp_ovf = ovf_q;
`endif

    // Operands stay on the adder in every state, so its inputs move only on acceptance.
    assign adder_a   = op_a_q;
    assign adder_b   = op_b_q;
    assign adder_cin = op_cin_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter; also checks rsp_ovf when ADDER_ARB_OVF_EN is defined.
module tb_adder_rr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 12;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready, req_cin;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0]      adder_a, adder_b, adder_sum, rsp_sum;
    logic                  adder_cin, adder_cout, rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]        rsp_id;
`ifdef ADDER_ARB_OVF_EN
    logic                  rsp_ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the external adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + 13'(adder_cin);

    adder_rr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
`ifdef ADDER_ARB_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b,
                          input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i] = c;
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef ADDER_ARB_OVF_EN
        chk(tag, 32'(rsp_ovf), 32'(exp));
`endif
    endtask

    // Entered and left at a negedge in IDLE; rsp_ready is expected high.
    task automatic txn(input string tag, input logic [3:0] mask, input logic [3:0] mask_after,
                       input logic [3:0] exp_ready, input logic [11:0] exp_a,
                       input logic [1:0] exp_id, input logic [11:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
        req_valid = mask;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        req_valid = mask_after;
        @(negedge clk);
        chk({tag, ".calc_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".calc_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".adder_a"}, 32'(adder_a), 32'(exp_a));
        @(negedge clk);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, ".sum"}, 32'(rsp_sum), 32'(exp_sum));
        chk({tag, ".cout"}, 32'(rsp_cout), 32'(exp_cout));
        chk_ovf({tag, ".ovf"}, exp_ovf);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] fair_sum [4];
        int          order    [5];
        fair_sum = '{12'h112, 12'h225, 12'h336, 12'h449};
        order    = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.adder_a", 32'(adder_a), 32'd0);
        chk("reset.adder_b", 32'(adder_b), 32'd0);
        chk("reset.adder_cin", 32'(adder_cin), 32'd0);
        chk("reset.rsp_sum", 32'(rsp_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: single request, 7FF + 001 overflows into the sign bit
        set_op(0, 12'h7FF, 12'h001, 1'b0);
        txn("single", 4'b0001, 4'b0000, 4'b0001, 12'h7FF, 2'd0, 12'h800, 1'b0, 1'b1);

        // 2: fairness from a fresh pointer, one grant every 3 cycles
        do_reset();
        set_op(0, 12'h111, 12'h001, 1'b0);
        set_op(1, 12'h222, 12'h002, 1'b1);
        set_op(2, 12'h333, 12'h003, 1'b0);
        set_op(3, 12'h444, 12'h004, 1'b1);
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (c % 3 == 0) begin
                chk("fair.grant", 32'(req_ready), 32'(1) << order[c/3]);
            end else begin
                chk("fair.no_grant", 32'(req_ready), 32'd0);
            end
            if (c % 3 == 2) begin
                chk("fair.valid", 32'(rsp_valid), 32'd1);
                chk("fair.id", 32'(rsp_id), 32'(order[c/3]));
                chk("fair.sum", 32'(rsp_sum), 32'(fair_sum[order[c/3]]));
            end
            if (c == 14) req_valid = '0;
            @(negedge clk);
        end

        // 3: backpressure with pointer at 1; requester 3 stays pending
        rsp_ready = 1'b0;
        req_valid = 4'b1100;
        #1;
        chk("bp.grant2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp.hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp.hold_id", 32'(rsp_id), 32'd2);
            chk("bp.hold_sum", 32'(rsp_sum), 32'h336);
            chk("bp.no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp.grant3", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp.sum3", 32'(rsp_sum), 32'h449);
        chk("bp.id3", 32'(rsp_id), 32'd3);
        @(negedge clk);

        // 4: carry path; requester 1 alone is granted on each visit
        set_op(1, 12'hFFF, 12'h000, 1'b1);
        txn("carry1", 4'b0010, 4'b0000, 4'b0010, 12'hFFF, 2'd1, 12'h000, 1'b1, 1'b0);
        set_op(1, 12'hFFF, 12'hFFF, 1'b1);
        txn("carry2", 4'b0010, 4'b0000, 4'b0010, 12'hFFF, 2'd1, 12'hFFF, 1'b1, 1'b0);

        // 5: pointer wrap 3 -> 0
        set_op(2, 12'h100, 12'h023, 1'b0);
        txn("wrap.pre", 4'b0100, 4'b0000, 4'b0100, 12'h100, 2'd2, 12'h123, 1'b0, 1'b0);
        set_op(0, 12'h0A0, 12'h00A, 1'b1);
        set_op(3, 12'h400, 12'h400, 1'b0);
        txn("wrap.g3", 4'b1001, 4'b1001, 4'b1000, 12'h400, 2'd3, 12'h800, 1'b0, 1'b1);
        txn("wrap.g0", 4'b1001, 4'b0000, 4'b0001, 12'h0A0, 2'd0, 12'h0AB, 1'b0, 1'b0);

        // 6: reset during CALC discards the operation and clears the pointer
        set_op(2, 12'h321, 12'h001, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("rst.grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("rst.calc_a", 32'(adder_a), 32'h321);
        rst = 1'b1;
        #1;
        chk("rst.adder_a", 32'(adder_a), 32'd0);
        chk("rst.adder_b", 32'(adder_b), 32'd0);
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn("rst.ptr0", 4'b1111, 4'b0000, 4'b0001, 12'h0A0, 2'd0, 12'h0AB, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
